// File: rtl/key_pkg.sv
// Shared constants and helpers for the push-button front end: debounce default
// and the one-hot blink-rate codes driven to the LED blinker.
package key_pkg;

    localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;

    localparam logic [3:0] RATE_X1 = 4'd1;
    localparam logic [3:0] RATE_X2 = 4'd2;
    localparam logic [3:0] RATE_X4 = 4'd4;
    localparam logic [3:0] RATE_X8 = 4'd8;

    function automatic logic [3:0] rate_of_key(input int idx);
        logic [3:0] code;
        case (idx)
            0:       code = RATE_X1;
            1:       code = RATE_X2;
            2:       code = RATE_X4;
            3:       code = RATE_X8;
            default: code = RATE_X1;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and
// registered press/release pulses that coincide with the level update.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        stable_d  = stable_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                // Raw level is active-low: a falling stable bit is a press.
                stable_d  = s2_q;
                press_d   = ~s2_q;
                release_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            stable_q  <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_n_i;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = ~stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// DE2 push-button conditioner: per-key debounce channels plus the registered
// blink-rate selector (lowest pressed key wins) and its update strobe.
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int NUM_KEYS        = 4
) (
    input  logic                CLOCK_50,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [3:0]          speed_sel,
    output logic                speed_upd
);

    logic [3:0] speed_sel_q, speed_sel_d;
    logic       speed_upd_q, speed_upd_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i    (CLOCK_50),
            .rst_ni   (RST_N),
            .key_n_i  (KEY[i]),
            .level_o  (key_level[i]),
            .press_o  (key_press[i]),
            .release_o(key_release[i])
        );
    end

    // Scan from the top so the lowest pressed index is the last to assign.
    always_comb begin
        speed_sel_d = speed_sel_q;
        speed_upd_d = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_press[i]) begin
                speed_sel_d = rate_of_key(i);
                speed_upd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            speed_sel_q <= RATE_X1;
            speed_upd_q <= 1'b0;
        end else begin
            speed_sel_q <= speed_sel_d;
            speed_upd_q <= speed_upd_d;
        end
    end

    assign speed_sel = speed_sel_q;
    assign speed_upd = speed_upd_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4 and hand-computed expectations.
module tb_key_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] key_level, key_press, key_release, speed_sel;
    logic       speed_upd;

    int errors = 0;
    int checks = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .NUM_KEYS       (4)
    ) dut (
        .CLOCK_50   (clk),
        .RST_N      (rst_n),
        .KEY        (key),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .speed_sel  (speed_sel),
        .speed_upd  (speed_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                             input logic [3:0] rel, input logic [3:0] sel, input logic upd);
        check({tag, ".level"},   32'(key_level),   32'(lvl));
        check({tag, ".press"},   32'(key_press),   32'(prs));
        check({tag, ".release"}, 32'(key_release), 32'(rel));
        check({tag, ".sel"},     32'(speed_sel),   32'(sel));
        check({tag, ".upd"},     32'(speed_upd),   32'(upd));
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 4'hF;
        tick(3);
        check_all("reset", 4'h0, 4'h0, 4'h0, 4'd1, 1'b0);
        rst_n = 1'b1;
        tick(1);
        check_all("post_reset", 4'h0, 4'h0, 4'h0, 4'd1, 1'b0);
        tick(2);

        // Clean press of key 0: accepted on the 6th edge.
        key = 4'hE;
        tick(5);
        check_all("press0_early", 4'h0, 4'h0, 4'h0, 4'd1, 1'b0);
        tick(1);
        check_all("press0_edge6", 4'h1, 4'h1, 4'h0, 4'd1, 1'b0);
        tick(1);
        check_all("press0_upd", 4'h1, 4'h0, 4'h0, 4'd1, 1'b1);
        tick(1);
        check("press0_upd_drop", 32'(speed_upd), 32'd0);

        // Bounce on key 2 never reaches the level.
        key = 4'hA;
        tick(3);
        key = 4'hE;
        tick(1);
        key = 4'hA;
        tick(3);
        key = 4'hE;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("bounce.level", 32'(key_level), 32'h1);
            check("bounce.press", 32'(key_press), 32'h0);
        end
        check("bounce.sel", 32'(speed_sel), 32'd1);

        // Key 3 press selects x8; its release leaves x8.
        key = 4'h6;
        tick(5);
        check("press3_early.level", 32'(key_level), 32'h1);
        tick(1);
        check_all("press3_edge6", 4'h9, 4'h8, 4'h0, 4'd1, 1'b0);
        tick(1);
        check_all("press3_upd", 4'h9, 4'h0, 4'h0, 4'd8, 1'b1);
        key = 4'hE;
        tick(6);
        check_all("rel3_edge6", 4'h1, 4'h0, 4'h8, 4'd8, 1'b0);
        tick(1);
        check_all("rel3_after", 4'h1, 4'h0, 4'h0, 4'd8, 1'b0);

        // Release key 0, then press keys 1 and 2 together.
        key = 4'hF;
        tick(6);
        check_all("rel0_edge6", 4'h0, 4'h0, 4'h1, 4'd8, 1'b0);
        tick(2);
        key = 4'h9;
        tick(6);
        check_all("simul_edge6", 4'h6, 4'h6, 4'h0, 4'd8, 1'b0);
        tick(1);
        check_all("simul_upd", 4'h6, 4'h0, 4'h0, 4'd2, 1'b1);

        // Reset in the middle of a key-1 debounce restarts the full count.
        key = 4'hF;
        tick(8);
        check("idle.level", 32'(key_level), 32'h0);
        key = 4'hD;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check_all("mid_reset", 4'h0, 4'h0, 4'h0, 4'd1, 1'b0);
        rst_n = 1'b1;
        tick(5);
        check_all("after_reset_edge5", 4'h0, 4'h0, 4'h0, 4'd1, 1'b0);
        tick(1);
        check_all("after_reset_edge6", 4'h2, 4'h2, 4'h0, 4'd1, 1'b0);
        tick(1);
        check_all("after_reset_upd", 4'h2, 4'h0, 4'h0, 4'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
